debug_cache_loader: RTL

Synthesizable debug master for the CPU's second (debug) BRAM ports; it is the initiator side of the A2/WD2/WE2/RD2 protocol. Load command: accepts a byte stream, packs bytes little-endian into 32-bit words and writes them sequentially from address 0. Dump command: reads words sequentially from address 0 and streams them out as bytes. It holds the core in reset while active, so the core never runs on partially loaded memory.

---
 rtl/cache_dbg_pkg.sv | 28 ++
 rtl/debug_cache_loader_if.sv | 64 ++++++
 rtl/byte_word_shifter.sv | 46 ++++
 rtl/debug_cache_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_dbg_pkg.sv
// Shared types and constants for the debug cache loader.
// Contents: FSM state enum, default BRAM depth, command opcode and cache-select
// encodings, and a word-index to byte-address helper.
package cache_dbg_pkg;

  localparam int unsigned BRAMWORDS = 4096;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_DUMP  = 1'b1;
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_INST = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LD_COLLECT,
    LD_WRITE,
    DP_ADDR,
    DP_WAIT,
    DP_SEND,
    DONE
  } state_t;

  // Word index to byte address on the A2 bus.
  function automatic logic [31:0] wordAddr(input logic [31:0] wordIdx);
    return {wordIdx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/debug_cache_loader_if.sv
// Handshake and cache debug-port bundle of the debug cache loader.
// master: the loader (drives cmd_ready, in_ready, out stream, A2/WD2/WE2,
//         core_rst_hold, done).
// slave:  the host / memory side (drives cmd, in stream, out_ready, RD2).
interface debug_cache_loader_if #(
  parameter int unsigned CNT_W = 13
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             cmd_sel;
  logic [CNT_W-1:0] cmd_count;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;

  logic [31:0]      CPU_Debug_DataCache_A2;
  logic [31:0]      CPU_Debug_DataCache_WD2;
  logic [3:0]       CPU_Debug_DataCache_WE2;
  logic [31:0]      CPU_Debug_DataCache_RD2;

  logic [31:0]      CPU_Debug_InstCache_A2;
  logic [31:0]      CPU_Debug_InstCache_WD2;
  logic [3:0]       CPU_Debug_InstCache_WE2;
  logic [31:0]      CPU_Debug_InstCache_RD2;

  logic             core_rst_hold;
  logic             done;

  modport master (
    input  cmd_valid, cmd_op, cmd_sel, cmd_count,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2,
    input  CPU_Debug_DataCache_RD2,
    output CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2,
    input  CPU_Debug_InstCache_RD2,
    output core_rst_hold, done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sel, cmd_count,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2,
    output CPU_Debug_DataCache_RD2,
    input  CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2,
    output CPU_Debug_InstCache_RD2,
    input  core_rst_hold, done
  );

endinterface

// File: rtl/byte_word_shifter.sv
// Little-endian byte<->word shifter with a byte counter.
// Ports: CPU_CLK, CPU_RST (sync, active-high); clear zeroes the word and count;
// pushEn/pushByte shift a byte in from the top (4 pushes leave byte 0 in [7:0]);
// loadEn/loadWord load a whole word; shiftEn drops the low byte;
// word/lowByte are the register contents; lastByte_c flags the 4th byte.
module byte_word_shifter
  import cache_dbg_pkg::*;
(
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        clear,
  input  logic        pushEn,
  input  logic [7:0]  pushByte,
  input  logic        loadEn,
  input  logic [31:0] loadWord,
  input  logic        shiftEn,
  output logic [31:0] word,
  output logic [7:0]  lowByte,
  output logic        lastByte_c
);

  logic [31:0] shReg;
  logic [1:0]  byteCnt;

  // Byte count wraps after four bytes, ready for the next word.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST || clear) begin
      shReg   <= '0;
      byteCnt <= '0;
    end else if (loadEn) begin
      shReg   <= loadWord;
      byteCnt <= '0;
    end else if (pushEn) begin
      shReg   <= {pushByte, shReg[31:8]};
      byteCnt <= byteCnt + 2'd1;
    end else if (shiftEn) begin
      shReg   <= {8'h00, shReg[31:8]};
      byteCnt <= byteCnt + 2'd1;
    end
  end

  assign word       = shReg;
  assign lowByte    = shReg[7:0];
  assign lastByte_c = (byteCnt == 2'd3);

endmodule

// File: rtl/debug_cache_loader.sv
// Debug master for the CPU's second BRAM ports (A2/WD2/WE2/RD2).
// Load: packs a byte stream little-endian into words written from address 0.
// Dump: reads words from address 0 and streams them out low byte first.
// Ports: CPU_CLK, CPU_RST (sync, active-high); bus (master modport) carries the
// command, in/out byte streams, both cache debug ports, core_rst_hold and done.
module debug_cache_loader
  import cache_dbg_pkg::*;
#(
  parameter int unsigned WORDS  = BRAMWORDS,
  parameter int unsigned CNT_W  = 13,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                CPU_CLK,
  input  logic                CPU_RST,
  debug_cache_loader_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned WAIT_W = $clog2(RD_LAT + 2);

  state_t            state;
  logic              selR;
  logic [CNT_W-1:0]  countR;
  logic [IDX_W-1:0]  idx;
  logic [WAIT_W-1:0] waitCnt;

  logic              cmdReady;
  logic              inReady;
  logic              outValid;
  logic              holdR;
  logic              doneR;
  logic [31:0]       dA2, dWD, iA2, iWD;
  logic [3:0]        dWE, iWE;

  logic              cmdFire_c, inFire_c, outFire_c;
  logic              lastWord_c, waitDone_c;
  logic [CNT_W-1:0]  clampCount_c;
  logic [31:0]       rdSel_c;
  logic              shClear_c, shPush_c, shLoad_c, shShift_c;
  logic [31:0]       shWord;
  logic [7:0]        shLowByte;
  logic              shLast_c;

  // Handshake decode and datapath helpers.
  always_comb begin
    cmdFire_c    = bus.cmd_valid && cmdReady;
    inFire_c     = bus.in_valid && inReady;
    outFire_c    = outValid && bus.out_ready;
    lastWord_c   = ((CNT_W'(idx) + CNT_W'(1)) == countR);
    waitDone_c   = (waitCnt == WAIT_W'(RD_LAT));
    clampCount_c = (bus.cmd_count > CNT_W'(WORDS)) ? CNT_W'(WORDS) : bus.cmd_count;
    rdSel_c      = (selR == SEL_INST) ? bus.CPU_Debug_InstCache_RD2
                                      : bus.CPU_Debug_DataCache_RD2;
    shClear_c    = (state == IDLE) && cmdFire_c;
    shPush_c     = (state == LD_COLLECT) && inFire_c;
    shLoad_c     = (state == DP_WAIT) && waitDone_c;
    shShift_c    = (state == DP_SEND) && outFire_c;
  end

  byte_word_shifter u_shifter (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST    (CPU_RST),
    .clear      (shClear_c),
    .pushEn     (shPush_c),
    .pushByte   (bus.in_data),
    .loadEn     (shLoad_c),
    .loadWord   (rdSel_c),
    .shiftEn    (shShift_c),
    .word       (shWord),
    .lowByte    (shLowByte),
    .lastByte_c (shLast_c)
  );

  // Command FSM; handshake readies/valids change together with the state so
  // they always reflect it, while hold/done/port drives follow one cycle later.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state    <= IDLE;
      selR     <= SEL_DATA;
      countR   <= '0;
      idx      <= '0;
      waitCnt  <= '0;
      cmdReady <= 1'b1;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      holdR    <= 1'b0;
      doneR    <= 1'b0;
      dA2      <= '0;
      dWD      <= '0;
      dWE      <= '0;
      iA2      <= '0;
      iWD      <= '0;
      iWE      <= '0;
    end else begin
      holdR <= (state != IDLE);
      doneR <= (state == DONE);
      dWE   <= '0;
      iWE   <= '0;

      case (state)
        IDLE: begin
          if (cmdFire_c) begin
            selR     <= bus.cmd_sel;
            countR   <= clampCount_c;
            idx      <= '0;
            cmdReady <= 1'b0;
            if (clampCount_c == '0) begin
              state <= DONE;
            end else if (bus.cmd_op == OP_LOAD) begin
              state   <= LD_COLLECT;
              inReady <= 1'b1;
            end else begin
              state <= DP_ADDR;
            end
          end
        end

        LD_COLLECT: begin
          if (inFire_c && shLast_c) begin
            state   <= LD_WRITE;
            inReady <= 1'b0;
          end
        end

        LD_WRITE: begin
          if (selR == SEL_DATA) begin
            dWE <= 4'hF;
            dA2 <= wordAddr(32'(idx));
            dWD <= shWord;
          end else begin
            iWE <= 4'hF;
            iA2 <= wordAddr(32'(idx));
            iWD <= shWord;
          end
          if (lastWord_c) begin
            state <= DONE;
          end else begin
            idx     <= idx + IDX_W'(1);
            state   <= LD_COLLECT;
            inReady <= 1'b1;
          end
        end

        DP_ADDR: begin
          if (selR == SEL_DATA) begin
            dA2 <= wordAddr(32'(idx));
          end else begin
            iA2 <= wordAddr(32'(idx));
          end
          waitCnt <= '0;
          state   <= DP_WAIT;
        end

        // Counts from the A2 update; RD2 is captured by the shifter on exit.
        DP_WAIT: begin
          if (waitDone_c) begin
            state    <= DP_SEND;
            outValid <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end

        DP_SEND: begin
          if (outFire_c && shLast_c) begin
            outValid <= 1'b0;
            if (lastWord_c) begin
              state <= DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= DP_ADDR;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          cmdReady <= 1'b1;
          dA2      <= '0;
          dWD      <= '0;
          iA2      <= '0;
          iWD      <= '0;
        end

        default: begin
          state    <= IDLE;
          cmdReady <= 1'b1;
          inReady  <= 1'b0;
          outValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready               = cmdReady;
  assign bus.in_ready                = inReady;
  assign bus.out_valid               = outValid;
  assign bus.out_data                = shLowByte;
  assign bus.CPU_Debug_DataCache_A2  = dA2;
  assign bus.CPU_Debug_DataCache_WD2 = dWD;
  assign bus.CPU_Debug_DataCache_WE2 = dWE;
  assign bus.CPU_Debug_InstCache_A2  = iA2;
  assign bus.CPU_Debug_InstCache_WD2 = iWD;
  assign bus.CPU_Debug_InstCache_WE2 = iWE;
  assign bus.core_rst_hold           = holdR;
  assign bus.done                    = doneR;

endmodule
